// File: rtl/chan_scan_mux.sv
// N-channel, W-bit registered selector. The channel steps on a debounced
// pushbutton press (manual) or a free-running divider (auto scan).
module chan_scan_mux #(
  parameter int W        = 7,
  parameter int N        = 4,
  parameter int SCAN_DIV = 50_000_000,
  parameter int DB       = 500_000,
  localparam int CW      = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N*W-1:0] din,
  input  logic          mode,
  input  logic          step_n,
  input  logic          freeze,
  output logic [W-1:0]  y,
  output logic [W-1:0]  y_n,
  output logic [CW-1:0] ch,
  output logic          ch_chg
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DB > 1) ? $clog2(DB) : 1;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB - 1);
  localparam logic [CW-1:0] CH_LAST   = CW'(N - 1);

  logic          r_sync1, r_sync2, r_db_lvl, r_press, r_mode_d, r_ch_chg;
  logic [DW-1:0] r_db_cnt;
  logic [SW-1:0] r_scan;
  logic [CW-1:0] r_ch;
  logic [W-1:0]  r_y;

  logic          w_s, w_mode_chg, w_scan_term, w_adv;
  logic [CW-1:0] w_ch_nxt;
  logic [W-1:0]  w_chan [N];

  for (genvar k = 0; k < N; k++) begin : g_chan
    assign w_chan[k] = din[k*W +: W];
  end

  assign w_s         = r_sync2;
  assign w_mode_chg  = (mode != r_mode_d);
  assign w_scan_term = (r_scan == SCAN_LAST);
  assign w_ch_nxt    = (r_ch == CH_LAST) ? '0 : r_ch + 1'b1;
  // A mode change restarts the scan, so a terminal count on that cycle is void.
  assign w_adv       = ~freeze & (mode ? (w_scan_term & ~w_mode_chg) : r_press);

  // Button: 2-FF synchroniser, stability counter, registered 1->0 press pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_db_lvl <= 1'b1;
      r_db_cnt <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= step_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (w_s != r_db_lvl) begin
        if (r_db_cnt == DB_LAST) begin
          r_db_lvl <= w_s;
          r_db_cnt <= '0;
          r_press  <= ~w_s;
        end else begin
          r_db_cnt <= r_db_cnt + 1'b1;
        end
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  // Tracks mode through reset so leaving reset is never seen as a mode change.
  always_ff @(posedge clk) r_mode_d <= mode;

  always_ff @(posedge clk) begin
    if (reset)
      r_scan <= '0;
    else if (w_mode_chg)
      r_scan <= '0;
    else if (!freeze)
      r_scan <= w_scan_term ? '0 : r_scan + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ch     <= '0;
      r_y      <= '0;
      r_ch_chg <= 1'b0;
    end else begin
      r_ch_chg <= 1'b0;
      if (w_adv && N > 1) begin
        r_ch     <= w_ch_nxt;
        r_ch_chg <= 1'b1;
      end
      if (!freeze) r_y <= w_chan[r_ch];
    end
  end

  assign y      = r_y;
  assign y_n    = ~r_y;
  assign ch     = r_ch;
  assign ch_chg = r_ch_chg;

endmodule

// File: doc/chan_scan_mux.md
# chan_scan_mux

Parametrised N-channel, W-bit registered selector. It succeeds the fixed 2:1 7-bit selector on the board datapath. The channel is stepped either by a debounced active-low pushbutton (manual mode) or by a free-running divider (auto-scan mode). It drives a W-bit registered output, an active-low copy for segment displays, the current channel index and a one-cycle channel-change strobe.

## Interface
- W, 7: data width per channel.
- N, 4: channel count, N ≥ 1, any integer (not restricted to powers of 2).
- SCAN_DIV, 50_000_000: clk cycles per auto-scan step, ≥ 1.
- DB, 500_000: consecutive stable cycles required to accept a button level change, ≥ 1.
- CW (local): max(1, $clog2(N)).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- reset  in  1  synchronous, active-high; sampled on clk rising edge.
- din  in  N*W  channel k occupies din[k*W +: W].
- mode  in  1  0 = manual step, 1 = auto scan.
- step_n  in  1  active-low pushbutton, asynchronous to clk.
- freeze  in  1  1 = hold channel, output and scan counter.
- y  out  W  registered selected data.
- y_n  out  W  bitwise ~y, for active-low segments.
- ch  out  CW  current channel index, 0..N-1.
- ch_chg  out  1  one-cycle pulse on the cycle ch takes a new value.

## Operation
- Reset values:
  - ch = 0, y = 0, y_n = all ones, ch_chg = 0.
  - Scan counter = 0, debounce counter = 0.
  - Synchroniser FFs and debounced level = 1 (released).
- Button path:
  - step_n passes through a 2-FF synchroniser, giving s.
  - If s ≠ debounced level, the debounce counter increments; otherwise it clears.
  - When the counter reaches DB-1 while s still differs, the debounced level takes s and the counter clears.
  - A press = debounced level 1→0 transition, giving a single-cycle `press`. A release generates nothing.
- Channel advance, gated off while freeze = 1:
  - mode = 0: on `press`, ch ← ch+1.
  - mode = 1: scan counter counts 0..SCAN_DIV-1. At SCAN_DIV-1 it wraps to 0 and ch ← ch+1. Presses are ignored.
  - Wrap rule: ch = N-1 advances to 0. For N = 1, ch stays 0 and ch_chg never asserts.
- ch_chg = 1 for exactly the cycle after the edge at which ch changed value.
- Output: every non-frozen cycle, y ← din[ch*W +: W], using the registered ch. y_n is combinational ~y.
- freeze = 1 effects:
  - ch, y and the scan counter hold.
  - Presses occurring during freeze are discarded, not queued.
  - The debouncer keeps running.
- Any change of mode clears the scan counter that cycle. ch is unaffected.
- Simultaneous press and scan terminal in auto mode: exactly one advance (scan only).
- Reset asserted mid-debounce or mid-scan: all state returns to reset values on that edge. A press in progress is lost.

## Timing
- Press latency: step_n falling at edge t and held low gives ch updated at edge t+2+DB and ch_chg high during the following cycle.
- Scan period: ch advances every SCAN_DIV cycles, with the first advance SCAN_DIV cycles after reset release or after a mode change.
- Data latency: y shows din of the new channel one edge after ch updates. A din change appears on y one edge later.
- Glitch rejection: any step_n pulse shorter than DB cycles after synchronisation produces no press.
- No combinational path from inputs to y, ch or ch_chg. y_n depends only on y.

## Test plan
Every scenario uses W=7, N=3, SCAN_DIV=4, DB=3, din = {7'h33, 7'h22, 7'h11} (ch0=0x11).
- Reset:
  - Hold reset 2 cycles → ch=0, y=0x00, y_n=0x7F, ch_chg=0.
  - One cycle after release → y=0x11, y_n=0x6E.
- Manual stepping:
  - mode=0, three clean presses (step_n low 10 cycles each, 10 high between) → ch 0→1→2→0.
  - y goes 0x22, 0x33, 0x11, with one ch_chg pulse per press.
- Debounce:
  - step_n low for 2 cycles then high → no ch change, no ch_chg.
  - step_n low 5 cycles → exactly one advance, at 2+3 edges after the falling edge.
- Auto scan:
  - mode=1 from reset → ch advances at cycles 4, 8, 12 (1, 2, 0).
  - Presses issued meanwhile cause no extra advance.
  - Toggling mode at cycle 6 postpones the next advance to cycle 10.
- Freeze:
  - In auto mode, freeze=1 for 6 cycles starting at scan count 2 → ch, y hold.
  - After release, the advance occurs 2 cycles later.
  - A press during freeze is dropped.
- Mid-operation reset: reset at scan count 3 with ch=2 → next cycle ch=0, y=0x00, and the scan restarts from 0.
